// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte ports, baud tick and serial line status of the shared UART transmitter
interface uart_tx_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IDXW = 1
);
  logic                 txclk_en;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*8-1:0]    req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 tx;
  logic                 busy;
  logic [IDXW-1:0]      grant_idx;
  logic                 tx_done;
  modport master (
    output txclk_en, req_valid, req_data,
    input  req_ready, tx, busy, grant_idx, tx_done
  );
  modport slave (
    input  txclk_en, req_valid, req_data,
    output req_ready, tx, busy, grant_idx, tx_done
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin shares one 8N1 UART tx line between NREQ byte requesters
module uart_tx_arbiter #(
  parameter int NREQ = 2,
  parameter int IDXW = 1
) (
  input  logic clk,
  input  logic rst_n,
  uart_tx_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START_WAIT, DATA, STOP, STOP_HOLD} state_t;
  state_t          state;
  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] winner;
  logic [IDXW-1:0] next_ptr;
  logic            any;
  logic [7:0]      shift;
  logic [2:0]      bit_cnt;
  // descending scan so the last overwrite is the first valid at or after rr_ptr
  always_comb begin
    winner = '0;
    any    = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        winner = IDXW'((int'(rr_ptr) + k) % NREQ);
        any    = 1'b1;
      end
    end
  end
  assign next_ptr      = (winner == IDXW'(NREQ - 1)) ? '0 : winner + 1'b1;
  assign bus.req_ready = (rst_n && state == IDLE && any) ? NREQ'(1) << winner : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.tx        <= 1'b1;
      bus.busy      <= 1'b0;
      bus.tx_done   <= 1'b0;
      bus.grant_idx <= '0;
      rr_ptr        <= '0;
      shift         <= '0;
      bit_cnt       <= '0;
    end else begin
      bus.tx_done <= 1'b0;
      if (state == IDLE) begin
        if (any) begin
          shift         <= bus.req_data[{winner, 3'b000} +: 8];
          bus.grant_idx <= winner;
          rr_ptr        <= next_ptr;
          bus.busy      <= 1'b1;
          state         <= START_WAIT;
        end
      end else if (bus.txclk_en) begin
        case (state)
          START_WAIT: begin
            bus.tx  <= 1'b0;
            bit_cnt <= '0;
            state   <= DATA;
          end
          DATA: begin
            bus.tx  <= shift[0];
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= STOP;
          end
          STOP: begin
            bus.tx <= 1'b1;
            state  <= STOP_HOLD;
          end
          STOP_HOLD: begin
            bus.tx_done <= 1'b1;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: random and directed requests, scoreboard fed at accept, line decoder checks frames
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int W = 2;
  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  uart_tx_arbiter_if #(.NREQ(N), .IDXW(W)) bus ();
  uart_tx_arbiter #(.NREQ(N), .IDXW(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int   checks = 0;
  int   errors = 0;
  int   tick_per = 16;
  int   n_acc = 0;
  int   n_done = 0;
  int   phase = 0;
  int   mdl_rr = 0;
  bit   awaiting = 1'b0;
  bit   prev_tk = 1'b0;
  bit   prev_hs = 1'b0;
  logic last_tx = 1'b1;
  logic [7:0] got;
  exp_t sb[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  initial begin
    int cnt;
    cnt = 0;
    bus.txclk_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (cnt >= tick_per - 1) begin
        cnt = 0;
        bus.txclk_en = 1'b1;
      end else begin
        cnt++;
        bus.txclk_en = 1'b0;
      end
    end
  end
  // line decoder and scoreboard: inputs sampled here take effect at the next posedge
  always @(negedge clk) begin : mon
    bit         done_now;
    bit         exp_busy;
    int         w;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] hs;
    exp_t       e;
    done_now = 1'b0;
    if (!rst_n) begin
      chk("rst_tx", bus.tx, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_done", bus.tx_done, 0);
      chk("rst_grant", bus.grant_idx, 0);
      sb.delete();
      phase = 0;
      awaiting = 1'b0;
      prev_tk = 1'b0;
      prev_hs = 1'b0;
      last_tx = 1'b1;
      mdl_rr = 0;
    end else begin
      if (prev_tk) begin
        if (phase == 0) begin
          if (awaiting) begin
            chk("start_bit", bus.tx, 0);
            awaiting = 1'b0;
            phase = 1;
          end else chk("idle_line", bus.tx, 1);
        end else if (phase <= 8) begin
          got[phase-1] = bus.tx;
          phase++;
        end else if (phase == 9) begin
          chk("stop_bit", bus.tx, 1);
          phase = 10;
        end else begin
          phase = 0;
          done_now = 1'b1;
          n_done++;
          if (sb.size() == 0) chk("unexpected_frame", sb.size(), 1);
          else begin
            e = sb.pop_front();
            chk("frame_data", got, e.data);
            chk("grant_idx", bus.grant_idx, e.idx);
          end
        end
      end else chk("tx_stable", bus.tx, last_tx);
      if (prev_hs) awaiting = 1'b1;
      exp_busy = awaiting || phase != 0;
      chk("tx_done", bus.tx_done, done_now);
      chk("busy", bus.busy, exp_busy);
      w = exp_busy ? -1 : pick(bus.req_valid, mdl_rr);
      exp_rdy = (w < 0) ? '0 : N'(1) << w;
      chk("req_ready", bus.req_ready, exp_rdy);
      hs = bus.req_valid & bus.req_ready;
      prev_hs = (w >= 0) && (hs != 0);
      if (prev_hs) begin
        sb.push_back('{w, bus.req_data[8*w +: 8]});
        mdl_rr = (w + 1) % N;
        n_acc++;
      end
      prev_tk = bus.txclk_en;
      last_tx = bus.tx;
    end
  end
  task automatic drive(input logic [N-1:0] v, input logic [N*8-1:0] d);
    bus.req_valid = v;
    bus.req_data  = d;
  endtask
  task automatic wait_acc(input int k);
    int t;
    int n;
    t = n_acc + k;
    n = 0;
    while (n_acc < t && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("accept_timeout", n_acc >= t, 1);
  endtask
  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while ((sb.size() != 0 || phase != 0 || awaiting) && n < lim) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("idle_timeout", n < lim, 1);
  endtask
  initial begin
    int n;
    bus.req_valid = '0;
    bus.req_data  = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    drive(4'b0001, 32'h0000_00A5);
    wait_acc(1);
    drive('0, '0);
    wait_idle(400);
    tick_per = 4;
    drive(4'b0011, 32'h0000_2211);
    wait_acc(3);
    drive('0, '0);
    wait_idle(400);
    drive(4'b1010, 32'h3C00_9600);
    wait_acc(2);
    drive('0, '0);
    wait_idle(400);
    tick_per = 8;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!bus.txclk_en && n < 50);
    drive(4'b0010, 32'h0000_C300);
    wait_acc(1);
    drive('0, '0);
    wait_idle(400);
    drive(4'b0100, 32'h00E7_0000);
    wait_acc(1);
    drive('0, '0);
    n = 0;
    while (phase != 6 && n < 400) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("reach_bit4_timeout", n < 400, 1);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    drive(4'b0001, 32'h0000_005A);
    wait_acc(1);
    drive('0, '0);
    wait_idle(400);
    tick_per = 2;
    repeat (200) @(posedge clk);
    #2;
    for (int it = 0; it < 150; it++) begin
      if (it % 25 == 0) tick_per = $urandom_range(1, 5);
      drive(($urandom_range(0, 3) == 0) ? '0 : N'($urandom), $urandom);
      repeat ($urandom_range(1, 40)) @(posedge clk);
      #2;
    end
    drive('0, '0);
    wait_idle(2000);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
